srv32_mem_resp: RTL and testbench

SRV32_MEM_RESP -- requirements
Module: srv32_mem_resp

---
 rtl/srv32_mem_resp.sv | 72 +++++++
 tb/tb_srv32_mem_resp.sv | 137 +++++++++++++
 2 files changed

// File: rtl/srv32_mem_resp.sv
// srv32_mem_resp: single-port RAM with fixed-priority grants and per-channel read-latency pipelines
module srv32_mem_resp #(
  parameter int AW     = 14,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        mem_stall,
  input  logic        imem_ready,
  output logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_rresp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_wready,
  output logic        dmem_wvalid,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  input  logic        dmem_rready,
  output logic        dmem_rvalid,
  input  logic [31:0] dmem_raddr,
  output logic        dmem_rresp,
  output logic [31:0] dmem_rdata
);
  logic [31:0]       mem [2**AW];
  logic              ok;
  logic [AW-1:0]     ia, wa, ra;
  logic [RD_LAT-1:0] iv_q, dv_q;
  logic [31:0]       id_q [RD_LAT];
  logic [31:0]       dd_q [RD_LAT];
  logic              unused;
  assign ok          = !resetb && !mem_stall;
  assign dmem_wvalid = ok && dmem_wready;
  assign dmem_rvalid = ok && dmem_rready && !dmem_wready;
  assign imem_valid  = ok && imem_ready && !dmem_wready && !dmem_rready;
  assign ia = imem_addr[AW+1:2];
  assign wa = dmem_waddr[AW+1:2];
  assign ra = dmem_raddr[AW+1:2];
  assign unused = ^{imem_addr[31:AW+2], imem_addr[1:0], dmem_waddr[31:AW+2], dmem_waddr[1:0],
                    dmem_raddr[31:AW+2], dmem_raddr[1:0]};
  always_ff @(posedge clk) begin
    if (dmem_wvalid)
      for (int b = 0; b < 4; b++)
        if (dmem_wstrb[b]) mem[wa][8*b +: 8] <= dmem_wdata[8*b +: 8];
  end
  // Data stages hold zero when empty so rdata is zero whenever rresp is low.
  always_ff @(posedge clk) begin
    if (resetb) begin
      iv_q <= '0;
      dv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        id_q[i] <= '0;
        dd_q[i] <= '0;
      end
    end else begin
      iv_q[0] <= imem_valid;
      dv_q[0] <= dmem_rvalid;
      id_q[0] <= imem_valid ? mem[ia] : '0;
      dd_q[0] <= dmem_rvalid ? mem[ra] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        iv_q[i] <= iv_q[i-1];
        dv_q[i] <= dv_q[i-1];
        id_q[i] <= id_q[i-1];
        dd_q[i] <= dd_q[i-1];
      end
    end
  end
  assign imem_rresp = iv_q[RD_LAT-1] && !resetb;
  assign dmem_rresp = dv_q[RD_LAT-1] && !resetb;
  assign imem_rdata = imem_rresp ? id_q[RD_LAT-1] : '0;
  assign dmem_rdata = dmem_rresp ? dd_q[RD_LAT-1] : '0;
endmodule

// File: tb/tb_srv32_mem_resp.sv
// tb_srv32_mem_resp: drives RD_LAT=1 and RD_LAT=3 instances with identical stimulus against a cycle-indexed model
module tb_srv32_mem_resp;
  logic        clk = 0;
  logic        resetb = 1, mem_stall = 0, imem_ready = 0, dmem_wready = 0, dmem_rready = 0;
  logic [31:0] imem_addr = 0, dmem_waddr = 0, dmem_wdata = 0, dmem_raddr = 0;
  logic [3:0]  dmem_wstrb = 0;
  logic        iv1, ir1, wv1, rv1, dr1, iv3, ir3, wv3, rv3, dr3;
  logic [31:0] id1, dd1, id3, dd3;
  int n_cmp = 0, n_bad = 0, c = 0;
  logic [31:0] mem_m [int];
  logic [31:0] ei1 [int], ed1 [int], ei3 [int], ed3 [int];

  always #5 clk = ~clk;

  srv32_mem_resp #(.AW(14), .RD_LAT(1)) u1 (
    .clk(clk), .resetb(resetb), .mem_stall(mem_stall),
    .imem_ready(imem_ready), .imem_valid(iv1), .imem_addr(imem_addr), .imem_rresp(ir1), .imem_rdata(id1),
    .dmem_wready(dmem_wready), .dmem_wvalid(wv1), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rready(dmem_rready), .dmem_rvalid(rv1), .dmem_raddr(dmem_raddr),
    .dmem_rresp(dr1), .dmem_rdata(dd1));

  srv32_mem_resp #(.AW(14), .RD_LAT(3)) u3 (
    .clk(clk), .resetb(resetb), .mem_stall(mem_stall),
    .imem_ready(imem_ready), .imem_valid(iv3), .imem_addr(imem_addr), .imem_rresp(ir3), .imem_rdata(id3),
    .dmem_wready(dmem_wready), .dmem_wvalid(wv3), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rready(dmem_rready), .dmem_rvalid(rv3), .dmem_raddr(dmem_raddr),
    .dmem_rresp(dr3), .dmem_rdata(dd3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd16384);
  endfunction

  function automatic logic [31:0] raddr();
    return ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  task automatic cyc(input bit rs, input bit st, input bit wr, input logic [31:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input bit rr, input logic [31:0] ra, input bit ir, input logic [31:0] ia);
    bit gw, gr, gi;
    logic [31:0] m;
    resetb = rs; mem_stall = st; dmem_wready = wr; dmem_waddr = wa; dmem_wdata = wd; dmem_wstrb = ws;
    dmem_rready = rr; dmem_raddr = ra; imem_ready = ir; imem_addr = ia;
    @(negedge clk);
    if (rs)
      for (int k = c; k < c + 5; k++) begin
        ei1.delete(k); ed1.delete(k); ei3.delete(k); ed3.delete(k);
      end
    gw = !rs && !st && wr;
    gr = !rs && !st && rr && !wr;
    gi = !rs && !st && ir && !wr && !rr;
    chk("grant_lat1", {61'd0, wv1, rv1, iv1}, {61'd0, gw, gr, gi});
    chk("grant_lat3", {61'd0, wv3, rv3, iv3}, {61'd0, gw, gr, gi});
    chk("imem_lat1", {31'd0, ir1, id1}, {31'd0, 1'(ei1.exists(c)), ei1.exists(c) ? ei1[c] : 32'd0});
    chk("dmem_lat1", {31'd0, dr1, dd1}, {31'd0, 1'(ed1.exists(c)), ed1.exists(c) ? ed1[c] : 32'd0});
    chk("imem_lat3", {31'd0, ir3, id3}, {31'd0, 1'(ei3.exists(c)), ei3.exists(c) ? ei3[c] : 32'd0});
    chk("dmem_lat3", {31'd0, dr3, dd3}, {31'd0, 1'(ed3.exists(c)), ed3.exists(c) ? ed3[c] : 32'd0});
    chk("both_rresp_lat1", {63'd0, ir1 & dr1}, 64'd0);
    chk("both_rresp_lat3", {63'd0, ir3 & dr3}, 64'd0);
    if (gr) begin
      ed1[c+1] = mem_m[widx(ra)];
      ed3[c+3] = mem_m[widx(ra)];
    end
    if (gi) begin
      ei1[c+1] = mem_m[widx(ia)];
      ei3[c+3] = mem_m[widx(ia)];
    end
    if (gw) begin
      m = mem_m.exists(widx(wa)) ? mem_m[widx(wa)] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (ws[b]) m[8*b +: 8] = wd[8*b +: 8];
      mem_m[widx(wa)] = m;
    end
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) cyc(1, 0, 1, 32'h100, 32'h1234, 4'hF, 1, 0, 1, 0);
    for (int w = 0; w < 16; w++) cyc(0, 0, 1, 32'(w) << 2, $urandom, 4'hF, 0, 0, 0, 0);
    // Full write then dmem read of the same word
    cyc(0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0);
    chk("full_write_read", {31'd0, dr1, dd1}, {31'd0, 1'b1, 32'hDEADBEEF});
    // Low-byte merge seen by an imem read
    cyc(0, 0, 1, 32'h100, 32'h000000AA, 4'b0001, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100);
    chk("partial_write_read", {31'd0, ir1, id1}, {31'd0, 1'b1, 32'hDEADBEAA});
    // Contention: the core holds losers until granted
    cyc(0, 0, 1, 32'h4, 32'h0BADF00D, 4'hF, 1, 32'h100, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h100, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
    idle(3);
    // Back-to-back imem reads
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
    chk("lat3_first_resp", {31'd0, ir3, id3}, {31'd0, 1'b1, mem_m[0]});
    idle(4);
    // Reset right after a read accept drops it
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0);
    cyc(1, 0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 1, 32'h100, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40000004);
    idle(4);
    // Stall with requests held; in-flight read still returns
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 32'hC, 32'h55AA55AA, 4'hF, 1, 32'h4, 1, 32'h8);
    cyc(0, 0, 1, 32'hC, 32'h55AA55AA, 4'hF, 1, 32'h4, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
    // Zero strobe write is accepted but changes nothing
    cyc(0, 0, 1, 32'h100, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFF0101, 0, 0);
    idle(4);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 2) == 0, raddr(), $urandom, 4'($urandom),
          $urandom_range(0, 1) == 1, raddr(), $urandom_range(0, 1) == 1, raddr());
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
